mem_cmd_master: RTL

Bus initiator for the `mem_cmd_*` / `mem_rsp_*` peripheral bus. It accepts single read or write requests from a CPU-side request port, decodes the peripheral select from the upper address bits, and drives one command pulse per request. It holds address and select stable until the responder's read data has been captured, then returns one response pulse. It sits between the CPU/debug bridge and the peripheral set (GPIO etc.), one instance per bus.

---
 rtl/mem_cmd_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_master.sv
// mem_cmd_master: single-outstanding bus initiator for the mem_cmd_*/mem_rsp_* bus.
// Accepts one CPU request, pulses one command, waits for selected read data
// and returns one response pulse.
// Optional feature: define MEM_CMD_MASTER_TIMEOUT_EN to build the read-wait
// timeout counter (TIMEOUT_CYCLES); without it WAIT_RD waits indefinitely.
module mem_cmd_master #(
    parameter int NR_PERIPHS     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [15:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_cmd_valid,
    output logic                       mem_cmd_wr,
    output logic [NR_PERIPHS-1:0]      mem_cmd_sel,
    output logic [11:0]                mem_cmd_addr,
    output logic [31:0]                mem_cmd_wdata,
    input  logic [32*NR_PERIPHS-1:0]   mem_rsp_rdata,
    input  logic [NR_PERIPHS-1:0]      mem_rsp_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  dec_err;
    logic [NR_PERIPHS-1:0] sel_dec;
    logic                  idx_err;
    logic                  sel_ready;
    logic [31:0]           rd_mux;
    logic                  timeout_hit;

    // Decode the one-hot select and the out-of-range flag from the request address
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NR_PERIPHS; i++) begin
            if (req_addr[15:12] == 4'(i)) begin
                sel_dec[i] = 1'b1;
            end
        end
        idx_err = ({1'b0, req_addr[15:12]} >= 5'(NR_PERIPHS));
    end

    // Only the selected responder's ready and data are seen; others are masked off
    always_comb begin
        sel_ready = |(mem_rsp_ready & mem_cmd_sel);
        rd_mux    = '0;
        for (int i = 0; i < NR_PERIPHS; i++) begin
            if (mem_cmd_sel[i]) begin
                rd_mux = rd_mux | mem_rsp_rdata[32*i +: 32];
            end
        end
    end

`ifdef MEM_CMD_MASTER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Wait counter: cleared while in CMD (the only way into WAIT_RD), counts WAIT_RD cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (state == CMD) begin
            wait_cnt <= 8'd0;
        end else if (state == WAIT_RD) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th WAIT_RD cycle; a ready in that same cycle still wins
    assign timeout_hit = (state == WAIT_RD) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only matters when the timeout counter is built
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded request handshake
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (mem_cmd_wr || dec_err) begin
                    state_next = RESP;
                end else begin
                    state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (sel_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered bus and response outputs; address/select held until RESP->IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cmd_valid <= 1'b0;
            mem_cmd_wr    <= 1'b0;
            mem_cmd_sel   <= '0;
            mem_cmd_addr  <= 12'd0;
            mem_cmd_wdata <= 32'd0;
            dec_err       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 32'd0;
            rsp_err       <= 1'b0;
        end else begin
            mem_cmd_valid <= 1'b0;
            rsp_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_wr    <= req_wr;
                        mem_cmd_sel   <= sel_dec;
                        mem_cmd_addr  <= req_addr[11:0];
                        mem_cmd_wdata <= req_wdata;
                        dec_err       <= idx_err;
                    end
                end
                CMD: begin
                    if (mem_cmd_wr || dec_err) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= dec_err;
                    end
                end
                WAIT_RD: begin
                    if (sel_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_mux;
                        rsp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    mem_cmd_wr    <= 1'b0;
                    mem_cmd_sel   <= '0;
                    mem_cmd_addr  <= 12'd0;
                    mem_cmd_wdata <= 32'd0;
                    dec_err       <= 1'b0;
                    rsp_rdata     <= 32'd0;
                    rsp_err       <= 1'b0;
                end
                default: begin
                    mem_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
